mdu_seq: RTL and testbench
==========================

// Module: mdu_seq
// PURPOSE
//  Multi-cycle multiply/divide unit for the E stage of the P7 pipeline, successor to the single-latency MDU.
//  Executes mult/multu/div/divu plus accumulate modes madd/maddu/msub/msubu.
//  Owns HI/LO and serves mfhi/mflo/mthi/mtlo.
//  Exposes a busy flag for the hazard unit and honours exception flush (req) from CP0.
// PARAMETERS
//  WIDTH     32  operand width; HI and LO are each WIDTH bits.
//  MULT_LAT  5   busy cycles for mult/multu/madd*/msub* (>=1).
//  DIV_LAT   10  busy cycles for div/divu (>=1).
// PORTS
//  clk      in   1      system clock; single clock domain.
//  reset_n  in   1      reset, asynchronous, active-low.
//  op       in   4      MDUOp code (`MDU_* in def.v).
//  start    in   1      launch a md/madd/msub op this cycle.
//  mt       in   1      write HI (op=`MDU_mthi) or LO (op=`MDU_mtlo) with a.
//  req      in   1      exception/interrupt taken on the E-stage instruction this cycle.
//  a        in   WIDTH  rs operand.
//  b        in   WIDTH  rt operand.
//  busy     out  1      operation in flight.
//  hi       out  WIDTH  HI register.
//  lo       out  WIDTH  LO register.
//  rd_data  out  WIDTH  hi if op=`MDU_mfhi, else lo; combinational.
// BEHAVIOUR
//  - Reset (reset_n=0, async): hi=0, lo=0, busy=0, counter=0, pending result=0.
//  - Start accepted when start=1 && busy=0 && req=0.
//    - Full result computed from a/b at accept and held in a pending {HI,LO} register.
//    - Counter loads MULT_LAT or DIV_LAT.
//    - busy=1 from the cycle after accept.
//    - Counter decrements each cycle; busy stays 1 for exactly LAT cycles.
//    - On the edge where the counter reaches 0: hi/lo <= pending and busy falls.
//    - New hi/lo are visible in the first cycle with busy=0.
//  - Arithmetic:
//    - mult: signed 2W product.
//    - multu: unsigned 2W product.
//    - madd/msub: {hi,lo} +/- signed product, mod 2^(2W).
//    - maddu/msubu: same, with unsigned product.
//    - Accumulate ops use the {hi,lo} value at accept.
//    - div: lo=signed quotient truncated toward zero; hi=remainder (sign of dividend).
//    - divu: unsigned quotient and remainder.
//    - Signed overflow (min/-1): lo=min, hi=0.
//  - Divide by zero (b=0): hi=a, lo={WIDTH{1'b1}}.
//    Latency is still DIV_LAT; no exception is raised.
//  - mt=1 && busy=0 && req=0: hi or lo <= a at the next edge; the other register is unchanged.
//  - start or mt while busy=1: ignored, no state change.
//    The hazard unit guarantees stall; the block stays deterministic regardless.
//  - start and mt in the same cycle: start wins; mt is ignored.
//  - req=1: suppresses start and mt that cycle.
//    An op already in flight is NOT cancelled; it completes and commits.
//  - reset_n low mid-operation: immediate abort; all state returns to reset values.
//  - Unknown op with start=1: treated as no-op; busy stays 0.
// STRUCTURE
//  - def.v gains these constants:
//    - widen `MDU_* to 4 bits and add `MDU_madd/maddu/msub/msubu;
//    - `MDU_LAT_MULT/`MDU_LAT_DIV defaults.
//  - Controller MDUOp output widens to 4 bits; MDU_start includes the madd/msub class.
//  - One sub-module is natural: mdu_arith (combinational result for op/a/b/{hi,lo}).
//    The sequential counter/commit logic stays in mdu_seq.
//  - Counter width: $clog2(max(MULT_LAT,DIV_LAT)+1).
// TESTING
//  1. mult a=0xFFFFFFFE(-2), b=3 -> busy high exactly 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFA.
//  2. div a=-7, b=2 -> busy high 10 cycles; then lo=0xFFFFFFFD, hi=0xFFFFFFFF.
//     divu a=7, b=0 -> hi=7, lo=0xFFFFFFFF.
//  3. mthi 0, mtlo 10; then madd a=3, b=4 -> hi=0, lo=22.
//     Then msubu a=1, b=23 -> {hi,lo}=0xFFFFFFFF_FFFFFFFF.
//  4. start with req=1 -> busy stays 0, hi/lo unchanged.
//     req=1 during cycle 3 of a running mult -> result still commits at cycle 5.
//  5. mt and second start during busy -> ignored; final hi/lo equal first op's result.
//     mfhi rd_data tracks hi combinationally.
//  6. reset_n low at cycle 2 of div -> busy=0, hi=lo=0 asynchronously.
//     No commit after release.

Source files
------------

// File: rtl/mdu_seq_pkg.sv
// Shared opcodes and default latencies for the multi-cycle multiply/divide unit.
// Opcodes are the 4-bit MDUOp values produced by the decoder.
package mdu_seq_pkg;

    typedef enum logic [3:0] {
        MDU_NOP   = 4'd0,
        MDU_MULT  = 4'd1,
        MDU_MULTU = 4'd2,
        MDU_DIV   = 4'd3,
        MDU_DIVU  = 4'd4,
        MDU_MFHI  = 4'd5,
        MDU_MFLO  = 4'd6,
        MDU_MTHI  = 4'd7,
        MDU_MTLO  = 4'd8,
        MDU_MADD  = 4'd9,
        MDU_MADDU = 4'd10,
        MDU_MSUB  = 4'd11,
        MDU_MSUBU = 4'd12
    } mdu_op_e;

    localparam int MDU_LAT_MULT = 5;
    localparam int MDU_LAT_DIV  = 10;

endpackage

// File: rtl/mdu_seq_if.sv
// Pipeline-side port bundle of the MDU: E-stage request signals in, HI/LO state and busy out.
// The pipeline drives the master side; the MDU implements the slave side.
interface mdu_seq_if #(
    parameter int WIDTH = 32
);
    logic [3:0]       op;
    logic             start;
    logic             mt;
    logic             req;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic [WIDTH-1:0] rd_data;

    modport master (
        output op, start, mt, req, a, b,
        input  busy, hi, lo, rd_data
    );

    modport slave (
        input  op, start, mt, req, a, b,
        output busy, hi, lo, rd_data
    );
endinterface

// File: rtl/mdu_seq_arith.sv
// Full {HI,LO} result for a multiply, accumulate or divide op, computed from op/a/b/{hi,lo}.
// Purely combinational (zero latency); no handshake, sampled by mdu_seq at accept.
// Backpressure: none, the caller decides when the result is captured.
module mdu_seq_arith
    import mdu_seq_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [3:0]         op,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic [WIDTH-1:0]   hi,
    input  logic [WIDTH-1:0]   lo,
    output logic [2*WIDTH-1:0] result,
    output logic               is_mul,
    output logic               is_div
);

    logic [2*WIDTH-1:0] prod_s, prod_u, acc;
    logic [WIDTH-1:0]   a_mag, b_mag, div_a, div_b, q_raw, r_raw, quo, rem;
    logic               sgn;

    always_comb begin
        acc    = {hi, lo};
        // Truncated product of sign-extended operands equals the signed product mod 2^(2W).
        prod_s = {{WIDTH{a[WIDTH-1]}}, a} * {{WIDTH{b[WIDTH-1]}}, b};
        prod_u = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};

        // Signed divide runs on magnitudes; min/-1 then wraps back to min with zero remainder.
        sgn   = (op == MDU_DIV);
        a_mag = a[WIDTH-1] ? -a : a;
        b_mag = b[WIDTH-1] ? -b : b;
        div_a = sgn ? a_mag : a;
        div_b = sgn ? b_mag : b;
        if (div_b == '0) begin
            div_b = {{(WIDTH-1){1'b0}}, 1'b1};
        end
        q_raw = div_a / div_b;
        r_raw = div_a % div_b;
        quo   = (sgn && (a[WIDTH-1] ^ b[WIDTH-1])) ? -q_raw : q_raw;
        rem   = (sgn && a[WIDTH-1]) ? -r_raw : r_raw;

        result = '0;
        is_mul = 1'b0;
        is_div = 1'b0;
        case (op)
            MDU_MULT:  begin result = prod_s;       is_mul = 1'b1; end
            MDU_MULTU: begin result = prod_u;       is_mul = 1'b1; end
            MDU_MADD:  begin result = acc + prod_s; is_mul = 1'b1; end
            MDU_MADDU: begin result = acc + prod_u; is_mul = 1'b1; end
            MDU_MSUB:  begin result = acc - prod_s; is_mul = 1'b1; end
            MDU_MSUBU: begin result = acc - prod_u; is_mul = 1'b1; end
            MDU_DIV, MDU_DIVU: begin
                is_div = 1'b1;
                result = (b == '0) ? {a, {WIDTH{1'b1}}} : {rem, quo};
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mdu_seq.sv
// Multi-cycle multiply/divide unit owning HI/LO; serves mfhi/mflo/mthi/mtlo.
// Latency: MULT_LAT or DIV_LAT busy cycles after accept; HI/LO update on the edge busy falls.
// Backpressure: start/mt are dropped while busy or while req is high; the hazard unit stalls on busy.
module mdu_seq
    import mdu_seq_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int MULT_LAT = MDU_LAT_MULT,
    parameter int DIV_LAT  = MDU_LAT_DIV
) (
    input logic      clk,
    input logic      reset_n,
    mdu_seq_if.slave bus
);

    localparam int MAX_LAT = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
    localparam int CNT_W   = $clog2(MAX_LAT + 1);

    typedef enum logic {ST_IDLE, ST_BUSY} state_e;

    state_e             state;
    logic [CNT_W-1:0]   cnt;
    logic [2*WIDTH-1:0] pending;
    logic [WIDTH-1:0]   hi_q, lo_q;
    logic [2*WIDTH-1:0] result;
    logic               is_mul, is_div;

    mdu_seq_arith #(.WIDTH(WIDTH)) u_arith (
        .op     (bus.op),
        .a      (bus.a),
        .b      (bus.b),
        .hi     (hi_q),
        .lo     (lo_q),
        .result (result),
        .is_mul (is_mul),
        .is_div (is_div)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            pending <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    // A start of any op shadows mt in the same cycle, even an unknown op.
                    if (bus.start && !bus.req) begin
                        if (is_mul || is_div) begin
                            pending <= result;
                            cnt     <= is_div ? CNT_W'(DIV_LAT) : CNT_W'(MULT_LAT);
                            state   <= ST_BUSY;
                        end
                    end else if (bus.mt && !bus.req) begin
                        if (bus.op == MDU_MTHI) hi_q <= bus.a;
                        if (bus.op == MDU_MTLO) lo_q <= bus.a;
                    end
                end
                ST_BUSY: begin
                    if (cnt == CNT_W'(1)) begin
                        hi_q  <= pending[2*WIDTH-1:WIDTH];
                        lo_q  <= pending[WIDTH-1:0];
                        cnt   <= '0;
                        state <= ST_IDLE;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.busy    = (state == ST_BUSY);
    assign bus.hi      = hi_q;
    assign bus.lo      = lo_q;
    assign bus.rd_data = (bus.op == MDU_MFHI) ? hi_q : lo_q;

endmodule

// File: tb/tb_mdu_seq.sv
// Bench for mdu_seq: vector table, random ops against a 64-bit arithmetic model, and hand-written corner sequences.
module tb_mdu_seq;
    import mdu_seq_pkg::*;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    mdu_seq_if #(.WIDTH(32)) bus ();

    mdu_seq #(.WIDTH(32), .MULT_LAT(5), .DIV_LAT(10)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a, b, pre_hi, pre_lo, exp_hi, exp_lo;
        int          lat;
    } vec_t;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic mt_write(input logic [3:0] op, input logic [31:0] val);
        bus.op = op; bus.a = val; bus.mt = 1'b1;
        step();
        bus.mt = 1'b0; bus.op = MDU_MFLO;
    endtask

    task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, output int cyc);
        bus.op = op; bus.a = a; bus.b = b; bus.start = 1'b1;
        step();
        bus.start = 1'b0; bus.op = MDU_MFLO;
        cyc = 0;
        while (bus.busy && cyc < 64) begin
            cyc++;
            step();
        end
    endtask

    // Reference: plain 64-bit arithmetic on the architectural definitions.
    function automatic logic [63:0] model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                          input logic [31:0] hi, input logic [31:0] lo);
        longint sa, sb, ua, ub, q, r;
        logic [63:0] acc;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'b0, a});
        ub = longint'({32'b0, b});
        acc = {hi, lo};
        case (op)
            MDU_MULT:  return 64'(sa * sb);
            MDU_MULTU: return 64'(ua * ub);
            MDU_MADD:  return acc + 64'(sa * sb);
            MDU_MADDU: return acc + 64'(ua * ub);
            MDU_MSUB:  return acc - 64'(sa * sb);
            MDU_MSUBU: return acc - 64'(ua * ub);
            MDU_DIV, MDU_DIVU: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                if (op == MDU_DIV) begin q = sa / sb; r = sa % sb; end
                else begin q = ua / ub; r = ua % ub; end
                return {r[31:0], q[31:0]};
            end
            default: return {hi, lo};
        endcase
    endfunction

    vec_t        vecs[10];
    logic [3:0]  rops[8];
    logic [31:0] m_hi, m_lo, ra, rb;
    logic [63:0] exp;
    logic [3:0]  rop;
    int          cyc;

    initial begin
        bus.op = MDU_MFLO; bus.start = 1'b0; bus.mt = 1'b0; bus.req = 1'b0;
        bus.a = '0; bus.b = '0;

        vecs[0] = '{MDU_MULT,  32'hFFFF_FFFE, 32'd3,        32'h0, 32'h0,  32'hFFFF_FFFF, 32'hFFFF_FFFA, 5};
        vecs[1] = '{MDU_DIV,   32'hFFFF_FFF9, 32'd2,        32'h0, 32'h0,  32'hFFFF_FFFF, 32'hFFFF_FFFD, 10};
        vecs[2] = '{MDU_DIVU,  32'd7,         32'd0,        32'h0, 32'h0,  32'd7,         32'hFFFF_FFFF, 10};
        vecs[3] = '{MDU_MADD,  32'd3,         32'd4,        32'h0, 32'd10, 32'h0,         32'd22,        5};
        vecs[4] = '{MDU_MSUBU, 32'd1,         32'd23,       32'h0, 32'd22, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5};
        vecs[5] = '{MDU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h0, 32'hFFFF_FFFE, 32'h0000_0001, 5};
        vecs[6] = '{MDU_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h0, 32'h0,         32'h8000_0000, 10};
        vecs[7] = '{MDU_MSUB,  32'hFFFF_FFFF, 32'd5,        32'h0, 32'd1,  32'h0,         32'd6,         5};
        vecs[8] = '{MDU_MADDU, 32'h8000_0000, 32'd2,        32'd1, 32'h1,  32'd2,         32'h1,         5};
        vecs[9] = '{MDU_DIVU,  32'hFFFF_FFF9, 32'd2,        32'h0, 32'h0,  32'd1,         32'h7FFF_FFFC, 10};
        rops = '{MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU, MDU_MADD, MDU_MADDU, MDU_MSUB, MDU_MSUBU};

        #12;
        check("reset_busy", 64'(bus.busy), 64'd0);
        check("reset_hilo", {bus.hi, bus.lo}, 64'd0);
        step();
        reset_n = 1'b1;
        step();

        for (int i = 0; i < 10; i++) begin
            mt_write(MDU_MTHI, vecs[i].pre_hi);
            mt_write(MDU_MTLO, vecs[i].pre_lo);
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, cyc);
            check($sformatf("vec%0d_lat", i), 64'(cyc), 64'(vecs[i].lat));
            check($sformatf("vec%0d_hi", i), 64'(bus.hi), 64'(vecs[i].exp_hi));
            check($sformatf("vec%0d_lo", i), 64'(bus.lo), 64'(vecs[i].exp_lo));
        end

        m_hi = $urandom; m_lo = $urandom;
        mt_write(MDU_MTHI, m_hi);
        mt_write(MDU_MTLO, m_lo);
        for (int i = 0; i < 40; i++) begin
            rop = rops[$urandom_range(0, 7)];
            ra = $urandom;
            case ($urandom_range(0, 5))
                0: rb = 32'd0;
                1: rb = 32'hFFFF_FFFF;
                2: rb = 32'(($urandom_range(1, 9)));
                default: rb = $urandom;
            endcase
            if ($urandom_range(0, 3) == 0) ra = 32'h8000_0000;
            exp = model(rop, ra, rb, m_hi, m_lo);
            run_op(rop, ra, rb, cyc);
            check($sformatf("rnd%0d_op%0d", i, rop), {bus.hi, bus.lo}, exp);
            check($sformatf("rnd%0d_lat", i), 64'(cyc), 64'((rop == MDU_DIV || rop == MDU_DIVU) ? 10 : 5));
            m_hi = exp[63:32]; m_lo = exp[31:0];
        end

        // start and mt both blocked by req
        mt_write(MDU_MTHI, 32'h1111_1111);
        mt_write(MDU_MTLO, 32'h2222_2222);
        bus.req = 1'b1; bus.op = MDU_MULT; bus.a = 32'd9; bus.b = 32'd9; bus.start = 1'b1;
        step();
        bus.start = 1'b0; bus.op = MDU_MTHI; bus.mt = 1'b1;
        step();
        check("req_start_busy", 64'(bus.busy), 64'd0);
        bus.mt = 1'b0; bus.req = 1'b0; bus.op = MDU_MFLO;
        step();
        check("req_hilo_kept", {bus.hi, bus.lo}, 64'h1111_1111_2222_2222);

        // req in busy cycle 3 does not cancel the op in flight
        bus.op = MDU_MULT; bus.a = 32'd7; bus.b = 32'd6; bus.start = 1'b1;
        step();
        bus.start = 1'b0; bus.op = MDU_MFLO;
        cyc = 0;
        while (bus.busy && cyc < 64) begin
            cyc++;
            bus.req = (cyc == 3);
            step();
        end
        bus.req = 1'b0;
        check("req_mid_lat", 64'(cyc), 64'd5);
        check("req_mid_res", {bus.hi, bus.lo}, 64'd42);

        // mt and a second start while busy are both ignored
        bus.op = MDU_MULT; bus.a = 32'd2; bus.b = 32'd3; bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        cyc = 0;
        while (bus.busy && cyc < 64) begin
            cyc++;
            bus.mt = (cyc == 2); bus.start = (cyc == 3);
            bus.op = (cyc == 2) ? MDU_MTHI : MDU_DIV;
            bus.a = (cyc == 2) ? 32'hDEAD_BEEF : 32'd100; bus.b = 32'd7;
            step();
        end
        bus.mt = 1'b0; bus.start = 1'b0; bus.op = MDU_MFLO;
        check("busy_ign_lat", 64'(cyc), 64'd5);
        check("busy_ign_res", {bus.hi, bus.lo}, 64'd6);
        step(); step();
        check("busy_ign_idle", 64'(bus.busy), 64'd0);

        // rd_data selects combinationally on op
        mt_write(MDU_MTHI, 32'hCAFE_0001);
        bus.op = MDU_MFHI; #1;
        check("mfhi_rd", 64'(bus.rd_data), 64'hCAFE_0001);
        bus.op = MDU_MFLO; #1;
        check("mflo_rd", 64'(bus.rd_data), 64'd6);
        mt_write(MDU_MTHI, 32'h0BAD_F00D);
        bus.op = MDU_MFHI; #1;
        check("mfhi_track", 64'(bus.rd_data), 64'h0BAD_F00D);
        bus.op = MDU_MFLO;

        // unknown op and start+mt collision
        bus.op = 4'hF; bus.start = 1'b1; bus.mt = 1'b1; bus.a = 32'h5;
        step();
        bus.start = 1'b0; bus.mt = 1'b0;
        check("unk_busy", 64'(bus.busy), 64'd0);
        check("unk_hilo", {bus.hi, bus.lo}, 64'h0BAD_F00D_0000_0006);
        bus.op = MDU_MTLO; bus.a = 32'h77; bus.start = 1'b1; bus.mt = 1'b1;
        step();
        bus.start = 1'b0; bus.mt = 1'b0; bus.op = MDU_MFLO;
        check("start_beats_mt", 64'(bus.lo), 64'd6);

        // async reset in busy cycle 2 of a divide
        mt_write(MDU_MTLO, 32'h55);
        bus.op = MDU_DIV; bus.a = 32'd100; bus.b = 32'd3; bus.start = 1'b1;
        step();
        bus.start = 1'b0; bus.op = MDU_MFLO;
        step();
        #2 reset_n = 1'b0;
        #1;
        check("rst_mid_busy", 64'(bus.busy), 64'd0);
        check("rst_mid_hilo", {bus.hi, bus.lo}, 64'd0);
        step();
        reset_n = 1'b1;
        for (int i = 0; i < 15; i++) step();
        check("rst_no_commit", {bus.hi, bus.lo}, 64'd0);
        check("rst_idle", 64'(bus.busy), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
